// File: rtl/effects_pipeline_mc.sv
// Multi-channel effects pipeline: centre, gain and clip/saturate ADC samples
// through three globally stalled stages with a valid/ready handshake.
module effects_pipeline_mc #(
   parameter int unsigned BITS_PER_LEVEL     = 12,
   parameter int unsigned BITS_PER_GAIN_FRAC = 4,
   parameter int unsigned GAIN_WIDTH         = 11,
   parameter int unsigned FXP_SIZE           = 16,
   parameter int unsigned CHANNELS           = 2,
   parameter int unsigned CNT_WIDTH          = 16,
   localparam int unsigned CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      i_valid,
   output logic                      o_ready_in,
   input  logic [BITS_PER_LEVEL-1:0] i_sample,
   input  logic [CH_W-1:0]           i_channel,
   input  logic [GAIN_WIDTH-1:0]     i_par_gain,
   input  logic [1:0]                i_par_mode,
   input  logic [BITS_PER_LEVEL-2:0] i_par_clip,
   input  logic                      i_clr_clip,
   output logic                      o_valid,
   input  logic                      i_ready,
   output logic [FXP_SIZE-1:0]       o_sample,
   output logic [CH_W-1:0]           o_channel,
   output logic [CNT_WIDTH-1:0]      o_clip_count
);

   localparam int unsigned P_W   = BITS_PER_LEVEL + GAIN_WIDTH + 1;
   localparam int unsigned SHIFT = FXP_SIZE - BITS_PER_LEVEL;
   localparam logic signed [P_W-1:0]  SAT_HI   = P_W'((2 ** (BITS_PER_LEVEL - 1)) - 1);
   localparam logic signed [P_W-1:0]  SAT_LO   = ~SAT_HI;
   localparam logic [GAIN_WIDTH-1:0]  GAIN_ONE = GAIN_WIDTH'(2 ** BITS_PER_GAIN_FRAC);
   localparam logic [1:0] MODE_BYPASS = 2'd0;
   localparam logic [1:0] MODE_SAT    = 2'd1;
   localparam logic [1:0] MODE_CLIP   = 2'd2;
   localparam logic [1:0] MODE_MUTE   = 2'd3;

   logic advance;

   logic                             s1_valid_q, s1_valid_d;
   logic signed [BITS_PER_LEVEL-1:0] s1_c_q, s1_c_d;
   logic [GAIN_WIDTH-1:0]            s1_gain_q, s1_gain_d;
   logic [1:0]                       s1_mode_q, s1_mode_d;
   logic [BITS_PER_LEVEL-2:0]        s1_thr_q, s1_thr_d;
   logic [CH_W-1:0]                  s1_ch_q, s1_ch_d;

   logic                             s2_valid_q, s2_valid_d;
   logic signed [P_W-1:0]            s2_p_q, s2_p_d;
   logic [1:0]                       s2_mode_q, s2_mode_d;
   logic [BITS_PER_LEVEL-2:0]        s2_thr_q, s2_thr_d;
   logic [CH_W-1:0]                  s2_ch_q, s2_ch_d;

   logic                             o_valid_q, o_valid_d;
   logic [FXP_SIZE-1:0]              o_sample_q, o_sample_d;
   logic [CH_W-1:0]                  o_channel_q, o_channel_d;
   logic                             o_clip_q, o_clip_d;
   logic [CNT_WIDTH-1:0]             clip_cnt_q, clip_cnt_d;

   logic signed [P_W-1:0]            c_ext, g_ext;
   logic signed [P_W-1:0]            v, hi, lo, r, thr_s;
   logic signed [BITS_PER_LEVEL-1:0] r_lvl;
   logic signed [FXP_SIZE-1:0]       r_fx;

   // Global stall: every stage moves only when the output slot frees up.
   assign advance    = !o_valid_q || i_ready;
   assign o_ready_in = advance;

   // S1: offset-binary to two's complement (flip MSB); bypass forces unity gain.
   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_c_d     = s1_c_q;
      s1_gain_d  = s1_gain_q;
      s1_mode_d  = s1_mode_q;
      s1_thr_d   = s1_thr_q;
      s1_ch_d    = s1_ch_q;
      if (advance) begin
         s1_valid_d = i_valid;
         s1_c_d     = signed'({~i_sample[BITS_PER_LEVEL-1], i_sample[BITS_PER_LEVEL-2:0]});
         s1_gain_d  = (i_par_mode == MODE_BYPASS) ? GAIN_ONE : i_par_gain;
         s1_mode_d  = i_par_mode;
         s1_thr_d   = i_par_clip;
         s1_ch_d    = i_channel;
      end
   end

   // S2: full-precision signed product with zero-extended unsigned gain.
   always_comb begin
      c_ext      = P_W'(s1_c_q);
      g_ext      = signed'(P_W'(s1_gain_q));
      s2_valid_d = s2_valid_q;
      s2_p_d     = s2_p_q;
      s2_mode_d  = s2_mode_q;
      s2_thr_d   = s2_thr_q;
      s2_ch_d    = s2_ch_q;
      if (advance) begin
         s2_valid_d = s1_valid_q;
         s2_p_d     = c_ext * g_ext;
         s2_mode_d  = s1_mode_q;
         s2_thr_d   = s1_thr_q;
         s2_ch_d    = s1_ch_q;
      end
   end

   // S3: drop gain fraction (floor), clamp per mode, scale to output format.
   always_comb begin
      v     = s2_p_q >>> BITS_PER_GAIN_FRAC;
      thr_s = signed'(P_W'(s2_thr_q));
      hi    = SAT_HI;
      lo    = SAT_LO;
      if (s2_mode_q == MODE_CLIP) begin
         hi = thr_s;
         lo = -thr_s;
      end
      r = v;
      if (v > hi)      r = hi;
      else if (v < lo) r = lo;
      if (s2_mode_q == MODE_MUTE) r = '0;
      r_lvl = BITS_PER_LEVEL'(r);
      r_fx  = FXP_SIZE'(r_lvl);

      o_valid_d   = o_valid_q;
      o_sample_d  = o_sample_q;
      o_channel_d = o_channel_q;
      o_clip_d    = o_clip_q;
      if (advance) begin
         o_valid_d   = s2_valid_q;
         o_sample_d  = r_fx <<< SHIFT;
         o_channel_d = s2_ch_q;
         o_clip_d    = ((s2_mode_q == MODE_SAT) || (s2_mode_q == MODE_CLIP)) && (r != v);
      end
   end

   // Clip counter: counts consumed clipped samples, saturates, clear wins.
   always_comb begin
      clip_cnt_d = clip_cnt_q;
      if (i_clr_clip)
         clip_cnt_d = '0;
      else if (o_valid_q && i_ready && o_clip_q && (clip_cnt_q != '1))
         clip_cnt_d = clip_cnt_q + CNT_WIDTH'(1);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1_valid_q  <= 1'b0;
         s1_c_q      <= '0;
         s1_gain_q   <= '0;
         s1_mode_q   <= '0;
         s1_thr_q    <= '0;
         s1_ch_q     <= '0;
         s2_valid_q  <= 1'b0;
         s2_p_q      <= '0;
         s2_mode_q   <= '0;
         s2_thr_q    <= '0;
         s2_ch_q     <= '0;
         o_valid_q   <= 1'b0;
         o_sample_q  <= '0;
         o_channel_q <= '0;
         o_clip_q    <= 1'b0;
         clip_cnt_q  <= '0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         s1_c_q      <= s1_c_d;
         s1_gain_q   <= s1_gain_d;
         s1_mode_q   <= s1_mode_d;
         s1_thr_q    <= s1_thr_d;
         s1_ch_q     <= s1_ch_d;
         s2_valid_q  <= s2_valid_d;
         s2_p_q      <= s2_p_d;
         s2_mode_q   <= s2_mode_d;
         s2_thr_q    <= s2_thr_d;
         s2_ch_q     <= s2_ch_d;
         o_valid_q   <= o_valid_d;
         o_sample_q  <= o_sample_d;
         o_channel_q <= o_channel_d;
         o_clip_q    <= o_clip_d;
         clip_cnt_q  <= clip_cnt_d;
      end
   end

   assign o_valid      = o_valid_q;
   assign o_sample     = o_sample_q;
   assign o_channel    = o_channel_q;
   assign o_clip_count = clip_cnt_q;

endmodule

// File: tb/tb_effects_pipeline_mc.sv
// Self-checking bench for effects_pipeline_mc: vector table plus scoreboard
// for ordering, backpressure, counter saturation/clear and reset behaviour.
module tb_effects_pipeline_mc;

   localparam int unsigned CNTW    = 4;
   localparam int          CNT_MAX = 15;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_valid;
   logic        o_ready_in;
   logic [11:0] i_sample;
   logic [0:0]  i_channel;
   logic [10:0] i_par_gain;
   logic [1:0]  i_par_mode;
   logic [10:0] i_par_clip;
   logic        i_clr_clip;
   logic        o_valid;
   logic        i_ready;
   logic [15:0] o_sample;
   logic [0:0]  o_channel;
   logic [CNTW-1:0] o_clip_count;

   effects_pipeline_mc #(.CNT_WIDTH(CNTW)) dut (
      .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready_in(o_ready_in),
      .i_sample(i_sample), .i_channel(i_channel), .i_par_gain(i_par_gain),
      .i_par_mode(i_par_mode), .i_par_clip(i_par_clip), .i_clr_clip(i_clr_clip),
      .o_valid(o_valid), .i_ready(i_ready), .o_sample(o_sample),
      .o_channel(o_channel), .o_clip_count(o_clip_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [11:0] sample;
      logic [10:0] gain;
      logic [1:0]  mode;
      logic [10:0] thr;
      logic [15:0] exp;
      logic        exp_clip;
   } vec_t;

   typedef struct {
      logic [15:0] s;
      logic        ch;
      logic        clip;
   } sb_t;

   int   checks = 0;
   int   errors = 0;
   int   exp_cnt = 0;
   sb_t  exp_q[$];
   sb_t  e;
   logic held_v = 1'b0;
   logic [15:0] held_s;
   logic        held_c;
   logic        consume_clip;
   logic [16:0] m;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Independent integer model: returns {clip, o_sample}.
   function automatic logic [16:0] model(input logic [11:0] s, input logic [10:0] g,
                                         input logic [1:0] mode, input logic [10:0] t);
      int c, gi, p, v, lo, hi, r;
      c  = int'(s) - 2048;
      gi = (mode == 2'd0) ? 16 : int'(g);
      p  = c * gi;
      v  = p >>> 4;
      hi = (mode == 2'd2) ? int'(t) : 2047;
      lo = (mode == 2'd2) ? -int'(t) : -2048;
      r  = (v > hi) ? hi : ((v < lo) ? lo : v);
      if (mode == 2'd3) r = 0;
      return {((mode == 2'd1) || (mode == 2'd2)) && (r != v), 16'(r * 16)};
   endfunction

   task automatic send(input logic [11:0] s, input logic [10:0] g, input logic [1:0] mode,
                       input logic [10:0] t, input logic ch, input logic [15:0] ex,
                       input logic ex_clip);
      int n = 0;
      i_valid = 1'b1; i_sample = s; i_par_gain = g; i_par_mode = mode;
      i_par_clip = t; i_channel = ch;
      @(negedge clk);
      while (!o_ready_in && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) begin
         checks++; errors++;
         $display("FAIL accept_timeout: o_ready_in stuck at 0, required 1");
      end
      @(posedge clk);
      exp_q.push_back('{ex, ch, ex_clip});
      #1 i_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         @(posedge clk);
         n++;
      end
      #1 chk("drain_empty", 32'(exp_q.size()), 32'd0);
   endtask

   // Scoreboard monitor, sampling on the falling edge.
   always @(negedge clk) begin
      if (!rst) begin
         held_v = 1'b0;
      end else begin
         chk("ready_in", 32'(o_ready_in), 32'(!o_valid || i_ready));
         chk("clip_count", 32'(o_clip_count), 32'(exp_cnt));
         if (held_v) begin
            chk("hold_valid", 32'(o_valid), 32'd1);
            chk("hold_sample", 32'(o_sample), 32'(held_s));
            chk("hold_channel", 32'(o_channel), 32'(held_c));
         end
         consume_clip = 1'b0;
         if (o_valid && i_ready) begin
            if (exp_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_output: got %0h, nothing expected", o_sample);
            end else begin
               e = exp_q.pop_front();
               chk("out_sample", 32'(o_sample), 32'(e.s));
               chk("out_channel", 32'(o_channel), 32'(e.ch));
               consume_clip = e.clip;
            end
         end
         if (i_clr_clip) exp_cnt = 0;
         else if (consume_clip && exp_cnt < CNT_MAX) exp_cnt++;
         held_v = o_valid && !i_ready;
         held_s = o_sample;
         held_c = o_channel;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      errors++;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t tbl[14];
      tbl[0]  = '{12'h000, 11'h010, 2'd0, 11'd0,   16'h8000, 1'b0};
      tbl[1]  = '{12'h800, 11'h010, 2'd0, 11'd0,   16'h0000, 1'b0};
      tbl[2]  = '{12'hFFF, 11'h010, 2'd0, 11'd0,   16'h7FF0, 1'b0};
      tbl[3]  = '{12'h900, 11'h018, 2'd1, 11'd0,   16'h1800, 1'b0};
      tbl[4]  = '{12'hC00, 11'h020, 2'd1, 11'd0,   16'h7FF0, 1'b1};
      tbl[5]  = '{12'hC00, 11'h010, 2'd2, 11'd500, 16'h1F40, 1'b1};
      tbl[6]  = '{12'h400, 11'h010, 2'd2, 11'd500, 16'hE0C0, 1'b1};
      tbl[7]  = '{12'hABC, 11'h010, 2'd3, 11'd0,   16'h0000, 1'b0};
      tbl[8]  = '{12'h801, 11'h010, 2'd2, 11'd0,   16'h0000, 1'b1};
      tbl[9]  = '{12'h800, 11'h010, 2'd2, 11'd0,   16'h0000, 1'b0};
      tbl[10] = '{12'h000, 11'h7FF, 2'd1, 11'd0,   16'h8000, 1'b1};
      tbl[11] = '{12'h7FF, 11'h008, 2'd1, 11'd0,   16'hFFF0, 1'b0};
      tbl[12] = '{12'h900, 11'h7FF, 2'd0, 11'd0,   16'h1000, 1'b0};
      tbl[13] = '{12'h801, 11'h001, 2'd1, 11'd0,   16'h0000, 1'b0};

      rst = 1'b0; i_valid = 1'b0; i_sample = '0; i_channel = '0; i_par_gain = '0;
      i_par_mode = '0; i_par_clip = '0; i_clr_clip = 1'b0; i_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_valid", 32'(o_valid), 32'd0);
      chk("rst_sample", 32'(o_sample), 32'd0);
      chk("rst_channel", 32'(o_channel), 32'd0);
      chk("rst_count", 32'(o_clip_count), 32'd0);
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      // Table vectors, back to back
      for (int i = 0; i < 14; i++)
         send(tbl[i].sample, tbl[i].gain, tbl[i].mode, tbl[i].thr, 1'(i),
              tbl[i].exp, tbl[i].exp_clip);
      drain();
      chk("table_clip_count", 32'(o_clip_count), 32'd5);

      // Gain change on the accept cycle of the second sample
      send(12'h900, 11'h010, 2'd1, 11'd0, 1'b0, 16'h1000, 1'b0);
      send(12'h900, 11'h020, 2'd1, 11'd0, 1'b1, 16'h2000, 1'b0);
      drain();

      // Backpressure: 10 samples with i_ready low for 5 cycles mid-stream
      fork
         begin
            for (int k = 0; k < 10; k++) begin
               m = model(12'(k * 257 + 16), 11'h010, 2'd0, 11'd0);
               send(12'(k * 257 + 16), 11'h010, 2'd0, 11'd0, 1'(k), m[15:0], m[16]);
            end
         end
         begin
            repeat (4) @(posedge clk);
            #1 i_ready = 1'b0;
            repeat (4) @(posedge clk);
            #1;
            chk("stall_valid", 32'(o_valid), 32'd1);
            chk("stall_ready_in", 32'(o_ready_in), 32'd0);
            @(posedge clk);
            #1 i_ready = 1'b1;
         end
      join
      drain();

      // Counter saturation: 12 more clips on top of 5
      for (int k = 0; k < 12; k++) begin
         m = model(12'hFFF, 11'h7FF, 2'd1, 11'd0);
         send(12'hFFF, 11'h7FF, 2'd1, 11'd0, 1'(k), m[15:0], m[16]);
      end
      drain();
      chk("sat_count", 32'(o_clip_count), 32'(CNT_MAX));

      // Clear together with a consumed clip
      send(12'hFFF, 11'h7FF, 2'd1, 11'd0, 1'b0, 16'h7FF0, 1'b1);
      begin
         int n = 0;
         while (!o_valid && n < 20) begin
            @(posedge clk);
            #1 n++;
         end
         chk("clr_wait_valid", 32'(o_valid), 32'd1);
      end
      i_clr_clip = 1'b1;
      @(posedge clk);
      #1 i_clr_clip = 1'b0;
      chk("clr_priority", 32'(o_clip_count), 32'd0);
      drain();

      // Reset mid-stream
      send(12'h900, 11'h010, 2'd1, 11'd0, 1'b1, 16'h1000, 1'b0);
      send(12'h900, 11'h010, 2'd1, 11'd0, 1'b0, 16'h1000, 1'b0);
      send(12'h900, 11'h010, 2'd1, 11'd0, 1'b1, 16'h1000, 1'b0);
      chk("pre_rst_valid", 32'(o_valid), 32'd1);
      rst = 1'b0;
      #1;
      chk("mid_rst_valid", 32'(o_valid), 32'd0);
      chk("mid_rst_sample", 32'(o_sample), 32'd0);
      chk("mid_rst_channel", 32'(o_channel), 32'd0);
      exp_q.delete();
      exp_cnt = 0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 chk("post_rst_idle", 32'(o_valid), 32'd0);

      // Latency after reset release
      i_valid = 1'b1; i_sample = 12'hA00; i_par_gain = 11'h010;
      i_par_mode = 2'd1; i_par_clip = '0; i_channel = 1'b1;
      @(posedge clk);
      exp_q.push_back('{16'h2000, 1'b1, 1'b0});
      #1 i_valid = 1'b0;
      chk("lat_edge0", 32'(o_valid), 32'd0);
      @(posedge clk);
      #1 chk("lat_edge1", 32'(o_valid), 32'd0);
      @(posedge clk);
      #1 chk("lat_edge2", 32'(o_valid), 32'd1);
      chk("lat_sample", 32'(o_sample), 32'h2000);
      drain();
      repeat (3) @(posedge clk);
      #1 chk("final_idle", 32'(o_valid), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/effects_pipeline_mc.md
Name: effects_pipeline_mc

Overview:
Parametrised, multi-channel successor of the single-channel effects pipeline. It accepts time-multiplexed ADC samples tagged with a channel ID and processes each one through centre, gain and clip/saturate stages. Output is signed fixed-point with a full valid/ready handshake and backpressure. The block also supports per-sample mode selection and a clip-event counter, and sits between the ADC deserialiser and the downstream effect/DAC chain.

Parameters:
BITS_PER_LEVEL, 12, width of unsigned offset-binary input sample
BITS_PER_GAIN_FRAC, 4, fractional bits of unsigned gain
GAIN_WIDTH, 11, total gain width (integer + fraction)
FXP_SIZE, 16, signed output width; must be >= BITS_PER_LEVEL
CHANNELS, 2, number of channels; CH_W = max(1, clog2(CHANNELS))
CNT_WIDTH, 16, clip counter width

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous reset, active-low
i_valid  in  1  input sample valid
o_ready_in  out  1  pipeline can accept input this cycle
i_sample  in  BITS_PER_LEVEL  unsigned offset-binary sample
i_channel  in  CH_W  channel tag for i_sample
i_par_gain  in  GAIN_WIDTH  unsigned gain, Q(GAIN_WIDTH-BITS_PER_GAIN_FRAC).BITS_PER_GAIN_FRAC
i_par_mode  in  2  0 bypass, 1 gain+saturate, 2 gain+hard clip, 3 mute
i_par_clip  in  BITS_PER_LEVEL-1  unsigned hard-clip threshold (mode 2)
i_clr_clip  in  1  synchronous clear of clip counter
o_valid  out  1  output sample valid
i_ready  in  1  downstream ready
o_sample  out  FXP_SIZE  signed output sample
o_channel  out  CH_W  channel tag of o_sample
o_clip_count  out  CNT_WIDTH  saturating count of clipped/saturated samples

Behaviour:
- Reset (rst=0, asynchronous): all stage valids 0, o_valid=0, o_sample=0, o_channel=0, o_clip_count=0. Data in flight is discarded; no output after release until new input is accepted.
- Pipeline: 3 registered stages, S1 centre, S2 multiply, S3 shift/clip/scale. With no stall, latency from accept to o_valid is 3 cycles. Throughput is 1 sample/cycle.
- Handshake: advance = !o_valid || i_ready; o_ready_in = advance. On advance all stages shift together (a global stall). An input is accepted when i_valid && o_ready_in. An output is consumed when o_valid && i_ready. While stalled, o_sample and o_channel hold stable.
- i_par_gain, i_par_mode, i_par_clip and i_channel are captured with the sample at acceptance and travel with it. Changing a parameter affects only samples accepted afterwards.
- S1: c = i_sample − 2^(BITS_PER_LEVEL−1), signed BITS_PER_LEVEL (0x000 → −2048, 0x800 → 0, 0xFFF → 2047).
- S2: p = c × {0,gain}, signed BITS_PER_LEVEL+GAIN_WIDTH+1 bits, full precision. Bypass forces gain = 1.0 (1<<BITS_PER_GAIN_FRAC).
- S3: v = p >>> BITS_PER_GAIN_FRAC (arithmetic, floor rounding). The per-mode result r is:
  - mode 0/1: r = clamp(v, −2^(BITS_PER_LEVEL−1), 2^(BITS_PER_LEVEL−1)−1)
  - mode 2: r = clamp(v, −thr, +thr), with thr = i_par_clip
  - mode 3: r = 0
- Output scaling: o_sample = r << (FXP_SIZE − BITS_PER_LEVEL). This cannot overflow.
- Clip event: r != v in modes 1/2.
  - The counter increments by 1 when a clip-flagged sample is consumed at the output.
  - The counter saturates at all-ones.
  - i_clr_clip has priority over a simultaneous increment (result 0).
- thr = 0 in mode 2 yields 0 for every nonzero v, and each such sample counts as clipped.
- i_channel values >= CHANNELS are passed through unchanged; no error is raised.

Test Plan:
- Mode 0, samples 0x000, 0x800, 0xFFF, i_ready=1 → 3 cycles later o_sample 0x8000, 0x0000, 0x7FF0 on consecutive cycles; clip count 0.
- Mode 1, sample 0x900, gain 0x018 (1.5) → o_sample 0x1800 (384<<4). Then sample 0xC00, gain 0x020 (2.0) → 0x7FF0, clip count 1.
- Mode 2, thr 500, gain 0x010: sample 0xC00 → 0x1F40 (+8000); sample 0x400 → 0xE0C0 (−8000); clip count +2. Mode 3 with any sample → 0x0000.
- Backpressure: stream 10 samples on alternating channels with i_ready held low for 5 cycles mid-stream. Required: o_ready_in low while full, outputs held stable, all 10 samples emitted in order with correct o_channel, none lost or duplicated.
- Parameter change: switch gain from 1.0 to 2.0 on the same cycle sample N is accepted. Sample N uses 2.0 and sample N−1 uses 1.0.
- Counter: drive clip count to all-ones; further clips keep it there. Asserting i_clr_clip together with a clip → 0. Asserting rst low mid-stream → o_valid drops immediately, and the first output after release comes 3 cycles after the next accept.
